// File: rtl/apb_master_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_master_arbiter_if                                           |
// | Brief    : Requester bundle plus APB master port for apb_master_arbiter    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface apb_master_arbiter_if #(
    parameter int NUM_REQ = 4
);
    // Local requester side; per-requester fields are packed with requester i at slice i
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      req_write;
    logic [NUM_REQ*32-1:0]   req_addr;
    logic [NUM_REQ*32-1:0]   req_wdata;
    logic [NUM_REQ*4-1:0]    req_strb;
    logic [NUM_REQ*3-1:0]    req_prot;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [31:0]             rsp_rdata;
    logic                    rsp_slverr;

    // APB fabric side
    logic                    PSEL;
    logic                    PENABLE;
    logic [31:0]             PADDR;
    logic                    PWRITE;
    logic [31:0]             PWDATA;
    logic [3:0]              PSTRB;
    logic [2:0]              PPROT;
    logic [31:0]             PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        input  PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_slverr,
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        output PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_slverr,
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_master_arbiter                                              |
// | Brief    : Round-robin sharing of one APB master port among NUM_REQ        |
// |            requesters; optional ACCESS timeout under APB_TIMEOUT_EN.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module apb_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    apb_master_arbiter_if.master bus
);

    localparam int                  c_IDXW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_IDXW-1:0]   c_LAST_RST = c_IDXW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]  c_ONE      = NUM_REQ'(1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = c_ST_IDLE,
        S_SETUP  = c_ST_SETUP,
        S_ACCESS = c_ST_ACCESS
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_param_check
        $error("apb_master_arbiter: NUM_REQ or TIMEOUT_CYCLES out of range");
    end

    state_t              r_state;
    state_t              w_state_nxt;

    logic [c_IDXW-1:0]   r_last_grant;
    logic [c_IDXW-1:0]   r_grant;
    logic [c_IDXW-1:0]   w_pick;
    logic [c_IDXW-1:0]   w_scan;
    logic                w_any;
    logic                w_handshake;
    logic [NUM_REQ-1:0]  w_req_ready;

    logic                w_psel;
    logic                w_penable;
    logic                w_complete;
    logic                w_abort;
    logic                w_tmo_hit;

    logic [31:0]         r_paddr;
    logic                r_pwrite;
    logic [31:0]         r_pwdata;
    logic [3:0]          r_pstrb;
    logic [2:0]          r_pprot;

    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [31:0]         r_rsp_rdata;
    logic                r_rsp_slverr;

    logic [31:0]         w_addr  [NUM_REQ];
    logic [31:0]         w_wdata [NUM_REQ];
    logic [3:0]          w_strb  [NUM_REQ];
    logic [2:0]          w_prot  [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr[gi]  = bus.req_addr[32*gi +: 32];
        assign w_wdata[gi] = bus.req_wdata[32*gi +: 32];
        assign w_strb[gi]  = bus.req_strb[4*gi +: 4];
        assign w_prot[gi]  = bus.req_prot[3*gi +: 3];
    end

    // Scan downward so the nearest requester after last_grant is the one that sticks
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        w_scan = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_scan = c_IDXW'((int'(r_last_grant) + k) % NUM_REQ);
            if (bus.req_valid[w_scan]) begin
                w_pick = w_scan;
                w_any  = 1'b1;
            end
        end
    end

    assign w_handshake = (r_state == S_IDLE) && w_any && !PRESET;

    always_comb begin
        w_req_ready = '0;
        if (w_handshake) begin
            w_req_ready[w_pick] = 1'b1;
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_tmo_cnt;

    // Counts ACCESS cycles without PREADY; hit marks the final allowed wait cycle
    always_ff @(posedge PCLK) begin
        if (PRESET || r_state == S_SETUP) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_ACCESS && !bus.PREADY) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    assign w_tmo_hit = (r_tmo_cnt == c_TMO_LAST);
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_psel      = 1'b0;
        w_penable   = 1'b0;
        w_complete  = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_psel      = 1'b1;
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
                if (bus.PREADY) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_last_grant <= c_LAST_RST;
            r_grant      <= '0;
            r_paddr      <= '0;
            r_pwrite     <= 1'b0;
            r_pwdata     <= '0;
            r_pstrb      <= '0;
            r_pprot      <= '0;
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_slverr <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            if (w_handshake) begin
                r_last_grant <= w_pick;
                r_grant      <= w_pick;
                r_paddr      <= w_addr[w_pick];
                r_pwrite     <= bus.req_write[w_pick];
                r_pwdata     <= w_wdata[w_pick];
                r_pstrb      <= w_strb[w_pick];
                r_pprot      <= w_prot[w_pick];
            end
            if (w_complete) begin
                r_rsp_valid  <= c_ONE << r_grant;
                r_rsp_rdata  <= r_pwrite ? 32'd0 : bus.PRDATA;
                r_rsp_slverr <= bus.PSLVERR;
            end else if (w_abort) begin
                r_rsp_valid  <= c_ONE << r_grant;
                r_rsp_rdata  <= 32'd0;
                r_rsp_slverr <= 1'b1;
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_rdata  = r_rsp_rdata;
    assign bus.rsp_slverr = r_rsp_slverr;
    assign bus.PSEL       = w_psel;
    assign bus.PENABLE    = w_penable;
    assign bus.PADDR      = r_paddr;
    assign bus.PWRITE     = r_pwrite;
    assign bus.PWDATA     = r_pwdata;
    assign bus.PSTRB      = r_pstrb;
    assign bus.PPROT      = r_pprot;

endmodule
`default_nettype wire
